// File: rtl/count_datapath.sv
// ---------------------------------------------------------------------------
// count_datapath
//   Loadable down-counter with a small IDLE/RUN/DONE controller. A load with a
//   non-zero preset starts a run; each enable in RUN decrements; reaching zero
//   ends the run with a single-cycle registered done pulse.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear (highest priority)
//   ld       in   load strobe, samples din
//   en       in   count-enable strobe (only acts in RUN)
//   din      in   [WIDTH-1:0] preset value
//   count    out  [WIDTH-1:0] registered counter value
//   zero     out  count == 0
//   busy     out  state is RUN
//   done     out  registered one-cycle terminal-count pulse
//
// Optional feature (macro AUTO_RELOAD_EN)
//   When defined, ld also captures din into a reload register and the terminal
//   count reloads the counter and stays in RUN instead of entering DONE.
// ---------------------------------------------------------------------------
module count_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_terminal_count;
    logic             w_terminal_stay_run;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
        end else if (!clr && ld) begin
            r_reload <= din;
        end
    end

    // Terminal count restarts from the captured preset and keeps running.
    assign w_terminal_count    = r_reload;
    assign w_terminal_stay_run = 1'b1;
`else
    assign w_terminal_count    = '0;
    assign w_terminal_stay_run = 1'b0;
`endif

    // State, counter and done pulse all update together on the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority clr > ld > en. done defaults low so it can only be a pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (ld) begin
            if (din != '0) begin
                w_state_nxt = RUN;
                w_count_nxt = din;
            end else begin
                w_state_nxt = DONE;
                w_count_nxt = '0;
                w_done_nxt  = 1'b1;
            end
        end else if (en && (r_state == RUN)) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                // count <= 1 is terminal; treating 0 the same way means the
                // counter can never wrap even from an unexpected state.
                w_count_nxt = w_terminal_count;
                w_state_nxt = w_terminal_stay_run ? RUN : DONE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);
    assign busy  = (r_state == RUN);
    assign done  = r_done;

endmodule

// File: tb/tb_count_datapath.sv
module tb_count_datapath;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             clr;
    logic             ld;
    logic             en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             busy;
    logic             done;

    count_datapath #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .ld      (ld),
        .en      (en),
        .din     (din),
        .count   (count),
        .zero    (zero),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic             ld;
        logic             en;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] c;
        logic             z;
        logic             b;
        logic             d;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic void add(input logic c_clr, input logic c_ld, input logic c_en,
                                input int c_din, input int e_cnt,
                                input logic e_z, input logic e_b, input logic e_d);
        vec_t v;
        v.clr = c_clr; v.ld = c_ld; v.en = c_en; v.din = WIDTH'(c_din);
        v.c = WIDTH'(e_cnt); v.z = e_z; v.b = e_b; v.d = e_d;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    endtask

    task automatic chk_all(input string tag, input int idx, input int e_c,
                           input logic e_z, input logic e_b, input logic e_d);
        chk({tag, ".count"}, idx, int'(count), e_c);
        chk({tag, ".zero"},  idx, int'(zero),  int'(e_z));
        chk({tag, ".busy"},  idx, int'(busy),  int'(e_b));
        chk({tag, ".done"},  idx, int'(done),  int'(e_d));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic c_clr, input logic c_ld, input logic c_en, input int c_din);
        @(negedge clk);
        clr = c_clr; ld = c_ld; en = c_en; din = WIDTH'(c_din);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        clr = 0; ld = 0; en = 0; din = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk_all("reset_async", 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk_all("reset_held", 0, 0, 1, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        //   clr ld en din   count z b d
        add(0, 1, 0, 3,     3, 0, 1, 0);   // load 3
        add(0, 0, 1, 0,     2, 0, 1, 0);
        add(0, 0, 1, 0,     1, 0, 1, 0);
        add(0, 0, 1, 0,     0, 1, 0, 1);   // terminal: DONE, pulse
        add(0, 0, 0, 0,     0, 1, 0, 0);   // pulse is one cycle
        add(0, 0, 1, 0,     0, 1, 0, 0);   // en ignored in DONE
        add(0, 1, 0, 5,     5, 0, 1, 0);   // load 5
        add(0, 0, 1, 0,     4, 0, 1, 0);
        add(0, 0, 0, 0,     4, 0, 1, 0);   // en low holds
        add(0, 0, 1, 0,     3, 0, 1, 0);
        add(0, 0, 0, 0,     3, 0, 1, 0);
        add(1, 1, 1, 9,     0, 1, 0, 0);   // clr beats ld and en
        add(0, 0, 1, 0,     0, 1, 0, 0);   // en ignored in IDLE, no wrap
        add(0, 1, 0, 0,     0, 1, 0, 1);   // ld 0 -> DONE with pulse
        add(0, 0, 1, 0,     0, 1, 0, 0);
        add(0, 0, 1, 0,     0, 1, 0, 0);
        add(0, 0, 1, 0,     0, 1, 0, 0);
        add(0, 0, 1, 0,     0, 1, 0, 0);
        add(0, 1, 0, 255,   255, 0, 1, 0); // all-ones preset
        add(0, 0, 1, 0,     254, 0, 1, 0);
        add(1, 0, 0, 0,     0, 1, 0, 0);   // clr mid-RUN, no done
        add(0, 1, 0, 1,     1, 0, 1, 0);
        add(0, 1, 1, 7,     7, 0, 1, 0);   // ld beats en, reload mid-run
        add(0, 1, 0, 1,     1, 0, 1, 0);
        add(0, 0, 1, 0,     0, 1, 0, 1);   // count 1 -> 0 with pulse
        add(0, 1, 0, 0,     0, 1, 0, 1);   // ld 0 in DONE pulses again
        add(0, 0, 0, 0,     0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].ld, vecs[i].en, int'(vecs[i].din));
            chk_all("vec", i, int'(vecs[i].c), vecs[i].z, vecs[i].b, vecs[i].d);
        end

        // Asynchronous reset mid-RUN at count 2 aborts without a done pulse.
        step(0, 1, 0, 4);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_all("pre_abort", 0, 2, 0, 1, 0);
        @(negedge clk);
        clr = 0; ld = 0; en = 1; din = '0;
        reset_n = 1'b0;
        #1;
        chk_all("abort", 0, 0, 1, 0, 0);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        chk_all("abort_edge", 0, 0, 1, 0, 0);   // en in IDLE still ignored
        step(0, 1, 0, 1);
        chk_all("post_abort", 0, 1, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_all("post_abort", 1, 0, 1, 0, 1);
        step(0, 0, 0, 0);
        chk_all("post_abort", 2, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_datapath.md
COUNT_DATAPATH -- requirements
Module: count_datapath

Interface
REQ-001 Parameter: WIDTH, 8, bit width of din and count.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: clr  input  1  synchronous clear, driven by the controller's reset output.
REQ-005 Port: ld  input  1  load strobe from the controller.
REQ-006 Port: en  input  1  count-enable strobe from the controller.
REQ-007 Port: din  input  WIDTH  preset value, sampled on ld.
REQ-008 Port: count  output  WIDTH  current counter value, registered.
REQ-009 Port: zero  output  1  high when count == 0.
REQ-010 Port: busy  output  1  high when state is RUN.
REQ-011 Port: done  output  1  registered one-cycle pulse on terminal count.

Function
REQ-012 Three states: IDLE, RUN and DONE, in a single registered state machine.
REQ-013 Input priority each cycle: clr > ld > en.
REQ-014 clr, any state: state <= IDLE, count <= 0, done <= 0; ld and en ignored that cycle.
REQ-015 ld with din != 0, any state: count <= din, state <= RUN, done <= 0.
REQ-016 ld with din == 0, any state: count <= 0, state <= DONE, done pulses high for 1 cycle.
REQ-017 RUN with en and count > 1: count <= count - 1, state stays RUN.
REQ-018 RUN with en and count == 1: count <= 0, state <= DONE, done high the cycle count first reads 0 (no AUTO_RELOAD_EN).
REQ-019 RUN with en low: count and state hold, done low.
REQ-020 IDLE or DONE with en high: ignored, count holds, no decrement below 0, no wrap to all-ones.
REQ-021 done lasts exactly one cycle per terminal event and never asserts in IDLE.
REQ-022 zero is combinational from count; busy is combinational from state.
REQ-023 Latency: ld to count valid = 1 cycle; en to decremented count = 1 cycle.
REQ-024 The decrement is WIDTH-bit unsigned with no carry out; underflow is unreachable by REQ-020.
REQ-025 DONE holds count = 0 until ld or clr.

Reset
REQ-026 reset_n low: asynchronous, state <= IDLE, count <= 0, done <= 0, reload register <= 0.
REQ-027 Deassertion is sampled at the clock edge; the first active edge obeys REQ-013..REQ-020.
REQ-028 reset_n asserted mid-RUN aborts the count immediately with no done pulse.
REQ-029 Reset outputs: count=0, zero=1, busy=0, done=0.

Configuration
REQ-030 Macro AUTO_RELOAD_EN, when defined: ld also captures din into a WIDTH-bit reload register.
REQ-031 With AUTO_RELOAD_EN, RUN with en and count == 1: count <= reload, state stays RUN, done pulses once.
REQ-032 With AUTO_RELOAD_EN, ld din == 0 still enters DONE, per REQ-016.
REQ-033 Without AUTO_RELOAD_EN: no reload register is synthesized, and behaviour is exactly REQ-018.

Verification
REQ-034 Reset then ld=1, din=3, then en=1 for 3 cycles -> count 3,2,1,0; done high only when count=0; state DONE; busy=0.
REQ-035 din=5 loaded, en toggled 1,0,1,0 -> count 4,4,3,3; done never high.
REQ-036 clr, ld and en all high with din=9 in RUN -> count=0, state IDLE, done=0.
REQ-037 ld with din=0 -> count=0, done one-cycle pulse, zero=1; then en=1 for 4 cycles -> count stays 0.
REQ-038 reset_n low for half a cycle mid-RUN at count=2 -> count=0 immediately, no done; after release, ld din=1 and en -> done pulses.
REQ-039 AUTO_RELOAD_EN defined, din=2, en held high 6 cycles -> count 2,1,2,1,2,1; done pulses on every reload; busy stays 1.
